// File: rtl/sdio_rxframer_pkg.sv
// Shared definitions for the SDIO data receive framer: bus-width encodings, CRC16 polynomial, FSM states.
package sdio_rxframer_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_CRC  = 3'd3,
      S_END  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [1:0]  WIDTH_1W   = 2'd0;
   localparam logic [1:0]  WIDTH_4W   = 2'd1;
   localparam logic [1:0]  WIDTH_8W   = 2'd2;
   localparam logic [15:0] CRC16_POLY = 16'h1021;

   // Requested widths the instance cannot carry collapse to 1-bit mode.
   function automatic logic [1:0] eff_width(input logic [1:0] req, input int numio);
      eff_width = WIDTH_1W;
      if (req == WIDTH_4W && numio >= 4) eff_width = WIDTH_4W;
      if (req == WIDTH_8W && numio >= 8) eff_width = WIDTH_8W;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] w);
      case (w)
         WIDTH_4W: lane_mask = 8'h0F;
         WIDTH_8W: lane_mask = 8'hFF;
         default:  lane_mask = 8'h01;
      endcase
   endfunction

   function automatic logic [5:0] lane_bits(input logic [1:0] w);
      case (w)
         WIDTH_4W: lane_bits = 6'd4;
         WIDTH_8W: lane_bits = 6'd8;
         default:  lane_bits = 6'd1;
      endcase
   endfunction

endpackage

// File: rtl/sdio_rxframer_crc16_lane.sv
// Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane; updates one bit per i_ce, zero latency to o_crc.
module sdio_rxframer_crc16_lane
   import sdio_rxframer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_ce,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;
   logic        w_fb;

   assign w_fb  = i_bit ^ r_crc[15];
   assign o_crc = r_crc;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_crc <= 16'h0000;
      end else if (i_ce) begin
         r_crc <= {r_crc[14:0], 1'b0} ^ ({16{w_fb}} & CRC16_POLY);
      end
   end

endmodule

// File: rtl/sdio_rxframer.sv
// SDIO host receive framer: start-bit hunt, word deserializer, per-lane CRC16 and end-bit check.
// o_valid 1 cycle after a word's last strobe, o_done 1 cycle after the end-bit strobe; no backpressure.
module sdio_rxframer
   import sdio_rxframer_pkg::*;
#(
   parameter int NUMIO     = 4,
   parameter int LGLEN     = 12,
   parameter int LGTIMEOUT = 23
)(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_en,
   input  logic [1:0]           i_width,
   input  logic [LGLEN-1:0]     i_length,
   input  logic [LGTIMEOUT-1:0] i_timeout,
   input  logic                 i_rx_strb,
   input  logic [7:0]           i_rx_data,
   output logic                 o_valid,
   output logic [31:0]          o_data,
   output logic                 o_last,
   output logic                 o_done,
   output logic                 o_err,
   output logic                 o_timeout,
   output logic                 o_busy
);

   state_t               r_state, w_state;
   logic [1:0]           r_wsel, w_wsel;
   logic [LGLEN-1:0]     r_len, w_len, r_bytes, w_bytes, w_bytes_inc;
   logic [4:0]           r_bitcnt, w_bitcnt;
   logic [5:0]           w_bitsum;
   logic [3:0]           r_crccnt, w_crccnt;
   logic [LGTIMEOUT-1:0] r_tmo, w_tmo;
   logic                 r_tmo_en, w_tmo_en;
   logic                 r_crc_err, w_crc_err;
   logic                 r_valid, w_valid, r_last, w_last;
   logic                 r_err, w_err, r_timeout, w_timeout;
   logic [31:0]          r_word, w_word, w_shifted;
   logic [7:0]           w_mask, w_act, w_exp;
   logic                 w_crc_clear, w_crc_ce;
   logic [15:0]          w_crc [NUMIO];

   for (genvar g = 0; g < NUMIO; g++) begin : g_lane
      sdio_rxframer_crc16_lane u_crc (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_clear (w_crc_clear),
         .i_ce    (w_crc_ce),
         .i_bit   (i_rx_data[g]),
         .o_crc   (w_crc[g])
      );
   end

   assign w_mask      = lane_mask(r_wsel);
   assign w_act       = i_rx_data & w_mask;
   assign w_bitsum    = {1'b0, r_bitcnt} + lane_bits(r_wsel);
   assign w_bytes_inc = r_bytes + LGLEN'(4);

   // Lane W-1 carries the earliest bit of each W-bit group, so it lands highest.
   always_comb begin
      case (r_wsel)
         WIDTH_4W: w_shifted = {r_word[27:0], i_rx_data[3:0]};
         WIDTH_8W: w_shifted = {r_word[23:0], i_rx_data};
         default:  w_shifted = {r_word[30:0], i_rx_data[0]};
      endcase
   end

   // CRC bits go out MSB first, so strobe k of the CRC phase carries crc[15-k].
   always_comb begin
      w_exp = 8'h00;
      for (int l = 0; l < NUMIO; l++) begin
         w_exp[l] = w_crc[l][4'd15 - r_crccnt];
      end
   end

   always_comb begin
      w_state     = r_state;
      w_wsel      = r_wsel;
      w_len       = r_len;
      w_bytes     = r_bytes;
      w_bitcnt    = r_bitcnt;
      w_crccnt    = r_crccnt;
      w_tmo       = r_tmo;
      w_tmo_en    = r_tmo_en;
      w_crc_err   = r_crc_err;
      w_word      = r_word;
      w_valid     = 1'b0;
      w_last      = 1'b0;
      w_err       = r_err;
      w_timeout   = r_timeout;
      w_crc_clear = 1'b0;
      w_crc_ce    = 1'b0;
      if (r_state != S_IDLE && !i_en) begin
         w_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_en && !o_done) begin
                  w_state     = S_WAIT;
                  w_wsel      = eff_width(i_width, NUMIO);
                  w_len       = i_length;
                  w_bytes     = '0;
                  w_bitcnt    = 5'd0;
                  w_crccnt    = 4'd0;
                  w_tmo       = i_timeout;
                  w_tmo_en    = (i_timeout != '0);
                  w_crc_err   = 1'b0;
                  w_err       = 1'b0;
                  w_timeout   = 1'b0;
                  w_word      = 32'h0;
                  w_crc_clear = 1'b1;
               end
            end
            S_WAIT: begin
               if (i_rx_strb) begin
                  if (w_act == 8'h00) begin
                     w_state = S_DATA;
                  end else if (r_tmo_en) begin
                     if (r_tmo == LGTIMEOUT'(1)) begin
                        w_state   = S_DONE;
                        w_err     = 1'b1;
                        w_timeout = 1'b1;
                     end else begin
                        w_tmo = r_tmo - LGTIMEOUT'(1);
                     end
                  end
               end
            end
            S_DATA: begin
               if (i_rx_strb) begin
                  w_crc_ce = 1'b1;
                  w_word   = w_shifted;
                  if (w_bitsum == 6'd32) begin
                     w_bitcnt = 5'd0;
                     w_valid  = 1'b1;
                     w_bytes  = w_bytes_inc;
                     if (w_bytes_inc == r_len) begin
                        w_last   = 1'b1;
                        w_state  = S_CRC;
                        w_crccnt = 4'd0;
                     end
                  end else begin
                     w_bitcnt = w_bitsum[4:0];
                  end
               end
            end
            S_CRC: begin
               if (i_rx_strb) begin
                  if (((w_exp ^ i_rx_data) & w_mask) != 8'h00) w_crc_err = 1'b1;
                  if (r_crccnt == 4'd15) w_state = S_END;
                  w_crccnt = r_crccnt + 4'd1;
               end
            end
            S_END: begin
               if (i_rx_strb) begin
                  w_state   = S_DONE;
                  w_err     = r_crc_err | (w_act != w_mask);
                  w_timeout = 1'b0;
               end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_wsel    <= WIDTH_1W;
         r_len     <= '0;
         r_bytes   <= '0;
         r_bitcnt  <= 5'd0;
         r_crccnt  <= 4'd0;
         r_tmo     <= '0;
         r_tmo_en  <= 1'b0;
         r_crc_err <= 1'b0;
         r_word    <= 32'h0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_wsel    <= w_wsel;
         r_len     <= w_len;
         r_bytes   <= w_bytes;
         r_bitcnt  <= w_bitcnt;
         r_crccnt  <= w_crccnt;
         r_tmo     <= w_tmo;
         r_tmo_en  <= w_tmo_en;
         r_crc_err <= w_crc_err;
         r_word    <= w_word;
         r_valid   <= w_valid;
         r_last    <= w_last;
         r_err     <= w_err;
         r_timeout <= w_timeout;
      end
   end

   assign o_valid   = r_valid & ~i_reset;
   assign o_last    = r_last & ~i_reset;
   assign o_data    = r_word;
   assign o_done    = (r_state == S_DONE) & ~i_reset;
   assign o_err     = o_done & r_err;
   assign o_timeout = o_done & r_timeout;
   assign o_busy    = (r_state != S_IDLE);

endmodule
